instr_cache_ctrl: RTL



---
 rtl/instr_cache_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/instr_cache_ctrl.sv
// Direct-mapped read-only instruction cache controller.
// Register-based storage, full-line burst refill, debug hit/miss counters.
module instr_cache_ctrl #(
   parameter int INDEX_BITS  = 4,
   parameter int OFFSET_BITS = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic [31:0] cpu_addr,
   output logic [31:0] cpu_instr,
   output logic        cpu_ready,
   output logic        cpu_stall,
   input  logic        flush,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rvalid,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
);

   localparam int TAG_BITS = 30 - INDEX_BITS - OFFSET_BITS;
   localparam int LINES    = 1 << INDEX_BITS;
   localparam int WORDS    = 1 << OFFSET_BITS;

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      REFILL,
      RESPOND
   } state_t;

   state_t state, state_nx;

   logic [29:0]            addr_q;
   logic [OFFSET_BITS-1:0] cnt;
   logic                   flush_pending;
   logic [LINES-1:0]       valid;
   logic [TAG_BITS-1:0]    tags [LINES];
   logic [31:0]            data [LINES][WORDS];
   logic [31:0]            instr_q;
   logic [31:0]            rd_data;

   logic [TAG_BITS-1:0]    tag_a;
   logic [INDEX_BITS-1:0]  idx;
   logic [OFFSET_BITS-1:0] word;
   logic                   hit;
   logic                   last;
   logic                   unused_bits;

   // Byte-offset bits never select anything in a word-wide fetch.
   assign unused_bits = ^cpu_addr[1:0];

   assign tag_a = addr_q[29 -: TAG_BITS];
   assign idx   = addr_q[OFFSET_BITS +: INDEX_BITS];
   assign word  = addr_q[OFFSET_BITS-1:0];
   assign hit   = valid[idx] && (tags[idx] == tag_a);
   assign last  = (cnt == OFFSET_BITS'(WORDS - 1));

   always_comb begin
      state_nx  = state;
      cpu_ready = 1'b0;
      cpu_stall = 1'b0;
      mem_req   = 1'b0;
      mem_addr  = '0;
      rd_data   = data[idx][word];
      unique case (state)
         IDLE: begin
            if (!(flush || flush_pending) && cpu_req)
               state_nx = LOOKUP;
         end
         LOOKUP: begin
            if (hit) begin
               cpu_ready = 1'b1;
               state_nx  = IDLE;
            end else begin
               state_nx  = REFILL;
            end
         end
         REFILL: begin
            mem_req   = 1'b1;
            cpu_stall = 1'b1;
            mem_addr  = {tag_a, idx, cnt, 2'b00};
            if (mem_rvalid && last)
               state_nx = RESPOND;
         end
         RESPOND: begin
            cpu_ready = 1'b1;
            state_nx  = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Output holds the last delivered instruction between responses.
   assign cpu_instr = cpu_ready ? rd_data : instr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         addr_q        <= '0;
         cnt           <= '0;
         flush_pending <= 1'b0;
         valid         <= '0;
         instr_q       <= '0;
         hit_cnt       <= '0;
         miss_cnt      <= '0;
      end else begin
         state <= state_nx;
         if (cpu_ready)
            instr_q <= rd_data;
         if (state == IDLE) begin
            if (flush || flush_pending) begin
               valid         <= '0;
               flush_pending <= 1'b0;
            end else if (cpu_req) begin
               addr_q <= cpu_addr[31:2];
            end
         end else if (flush) begin
            flush_pending <= 1'b1;
         end
         if (state == LOOKUP) begin
            if (hit) begin
               if (hit_cnt != '1)
                  hit_cnt <= hit_cnt + 32'd1;
            end else begin
               cnt <= '0;
               if (miss_cnt != '1)
                  miss_cnt <= miss_cnt + 32'd1;
            end
         end
         if (state == REFILL && mem_rvalid) begin
            cnt <= cnt + 1'b1;
            if (last)
               valid[idx] <= 1'b1;
         end
      end
   end

   // Line storage needs no reset; the valid bits gate every use.
   always_ff @(posedge clk) begin
      if (state == REFILL && mem_rvalid) begin
         data[idx][cnt] <= mem_rdata;
         if (last)
            tags[idx] <= tag_a;
      end
   end

endmodule
